// File: rtl/cpu_multi.sv
// cpu_multi: multi-cycle RV32I subset core (addi/add/sub/lw/sw/beq/bne).
// Program is loaded through a serial port, then run from PC=0 until IR==0.
module cpu_multi (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] ins,
    input  logic        start,
    output logic        valid,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [31:0] imem_q [32];
    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [32];

    logic        imem_we;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        dm_we;
    logic [4:0]  dm_wa;
    logic [31:0] dm_wd;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic        is_addi;
    logic        is_add;
    logic        is_sub;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_bne;
    logic        is_br;
    logic        br_take;

    assign valid  = valid_q;
    assign pc     = pc_q;
    assign halted = halted_q;

    // Instruction field extraction and class decode from the held IR
    always_comb begin
        opcode  = ir_q[6:0];
        rd      = ir_q[11:7];
        funct3  = ir_q[14:12];
        rs1     = ir_q[19:15];
        rs2     = ir_q[24:20];
        funct7  = ir_q[31:25];
        imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
        imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                   ir_q[30:25], ir_q[11:8], 1'b0};
        is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
        is_add  = (opcode == OP_REG) && (funct3 == 3'b000)
                  && (funct7 == 7'b0000000);
        is_sub  = (opcode == OP_REG) && (funct3 == 3'b000)
                  && (funct7 == 7'b0100000);
        is_lw   = (opcode == OP_LOAD) && (funct3 == 3'b010);
        is_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
        is_beq  = (opcode == OP_BR) && (funct3 == 3'b000);
        is_bne  = (opcode == OP_BR) && (funct3 == 3'b001);
        is_br   = is_beq || is_bne;
        br_take = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    end

    // Next-state, datapath register and memory write-port computation
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        valid_d  = 1'b0;
        halted_d = halted_q;
        imem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = rd;
        rf_wd    = alu_q;
        dm_we    = 1'b0;
        dm_wa    = alu_q[6:2];
        dm_wd    = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    imem_we = 1'b1;
                    ptr_d   = ptr_q + 5'd1;
                end else if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[pc_q[6:2]];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = rf_q[rs1];
                b_d = rf_q[rs2];
                unique case (1'b1)
                    is_sw:   imm_d = imm_s;
                    is_br:   imm_d = imm_b;
                    default: imm_d = imm_i;
                endcase
                if (ir_q == '0) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_addi: begin
                        alu_d   = a_q + imm_q;
                        state_d = S_WB;
                    end
                    is_add: begin
                        alu_d   = a_q + b_q;
                        state_d = S_WB;
                    end
                    is_sub: begin
                        alu_d   = a_q - b_q;
                        state_d = S_WB;
                    end
                    is_lw, is_sw: begin
                        alu_d   = a_q + imm_q;
                        state_d = S_MEM;
                    end
                    is_br: begin
                        pc_d    = br_take ? pc_q + imm_q
                                          : pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        pc_d    = pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (is_lw) begin
                    mdr_d   = dmem_q[alu_q[6:2]];
                    state_d = S_WB;
                end else begin
                    dm_we   = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                rf_we   = (rd != 5'd0);
                rf_wd   = is_lw ? mdr_q : alu_q;
                pc_d    = pc_q + 32'd4;
                valid_d = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered control/datapath outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ptr_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ptr_q    <= ptr_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Instruction memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!rst && imem_we) begin
            imem_q[ptr_q] <= ins;
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Data memory, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                dmem_q[i] <= '0;
            end
        end else if (dm_we) begin
            dmem_q[dm_wa] <= dm_wd;
        end
    end

endmodule

// File: tb/tb_cpu_multi.sv
// tb_cpu_multi: directed programs for cpu_multi with hand-computed results.
// Checks retire pulses, PC trace, register/data memory state and reset abort.
module tb_cpu_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] ins;
    logic        start;
    logic        valid;
    logic [31:0] pc;
    logic        halted;

    int          n_chk = 0;
    int          n_fail = 0;
    int          nvalid;
    int          cyc;
    int          vcyc[$];
    logic [31:0] vpc[$];
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    cpu_multi dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .ins    (ins),
        .start  (start),
        .valid  (valid),
        .pc     (pc),
        .halted (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                          input int rd);
        logic [11:0] i12;
        logic [4:0]  r1;
        logic [4:0]  rdd;
        i12 = imm[11:0];
        r1  = rs1[4:0];
        rdd = rd[4:0];
        return {i12, r1, 3'b000, rdd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input int imm, input int rs1,
                                           input int rd);
        logic [11:0] i12;
        logic [4:0]  r1;
        logic [4:0]  rdd;
        i12 = imm[11:0];
        r1  = rs1[4:0];
        rdd = rd[4:0];
        return {i12, r1, 3'b010, rdd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input int imm, input int rs2,
                                           input int rs1);
        logic [11:0] i12;
        logic [4:0]  r1;
        logic [4:0]  r2;
        i12 = imm[11:0];
        r1  = rs1[4:0];
        r2  = rs2[4:0];
        return {i12[11:5], r2, r1, 3'b010, i12[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2,
                                          input int rs1, input int rd);
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rdd;
        r1  = rs1[4:0];
        r2  = rs2[4:0];
        rdd = rd[4:0];
        return {f7, r2, r1, 3'b000, rdd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2,
                                          input int rs1, input logic [2:0] f3);
        logic [12:0] b;
        logic [4:0]  r1;
        logic [4:0]  r2;
        b  = imm[12:0];
        r1 = rs1[4:0];
        r2 = rs2[4:0];
        return {b[12], b[10:5], r2, r1, f3, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        ins   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog();
        foreach (prog[i]) begin
            load = 1'b1;
            ins  = prog[i];
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic run(input int budget);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
        nvalid = 0;
        vcyc.delete();
        vpc.delete();
        while (!halted && cyc < budget) begin
            if (valid) begin
                nvalid++;
                vcyc.push_back(cyc);
                vpc.push_back(pc);
            end
            @(negedge clk);
            cyc++;
        end
        chk("run_halted", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc[7];
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        ins   = '0;

        do_reset();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        prog = '{32'h01308093, 32'h00002103, 32'h003101B3, 32'h00000000};
        load_prog();
        run(200);
        chk("p1_x1", dut.rf_q[1], 32'd19);
        chk("p1_x2", dut.rf_q[2], 32'd0);
        chk("p1_x3", dut.rf_q[3], 32'd0);
        chk("p1_nvalid", nvalid, 32'd3);
        repeat (3) @(negedge clk);
        chk("p1_halt_hold", {31'd0, halted}, 32'd1);
        chk("p1_halt_pc", pc, 32'd12);

        do_reset();
        prog = '{enc_i(5, 0, 1), enc_sw(4, 1, 0), enc_lw(4, 0, 2), 32'd0};
        load_prog();
        run(200);
        chk("p2_dmem1", dut.dmem_q[1], 32'd5);
        chk("p2_x2", dut.rf_q[2], 32'd5);
        chk("p2_nvalid", nvalid, 32'd3);
        if (nvalid == 3) begin
            chk("p2_sw_gap", vcyc[1] - vcyc[0], 32'd4);
            chk("p2_lw_gap", vcyc[2] - vcyc[1], 32'd5);
        end

        do_reset();
        prog = '{enc_i(3, 0, 1), enc_i(-1, 1, 1),
                 enc_b(-4, 0, 1, 3'b001), 32'd0};
        load_prog();
        run(400);
        chk("p3_x1", dut.rf_q[1], 32'd0);
        chk("p3_nvalid", nvalid, 32'd7);
        chk("p3_pc", pc, 32'd12);
        exp_pc = '{32'd4, 32'd8, 32'd4, 32'd8, 32'd4, 32'd8, 32'd12};
        if (nvalid == 7) begin
            for (int i = 0; i < 7; i++) begin
                chk($sformatf("p3_trace%0d", i), vpc[i], exp_pc[i]);
            end
        end

        do_reset();
        prog = '{enc_i(1, 0, 0), 32'd0};
        load_prog();
        run(200);
        chk("p4_x0", dut.rf_q[0], 32'd0);
        chk("p4_nvalid", nvalid, 32'd1);

        do_reset();
        prog.delete();
        prog.push_back(enc_i(1, 0, 5));
        for (int i = 1; i < 32; i++) prog.push_back(32'd0);
        prog.push_back(enc_i(7, 0, 5));
        load_prog();
        chk("p5_imem0", dut.imem_q[0], enc_i(7, 0, 5));
        run(200);
        chk("p5_x5", dut.rf_q[5], 32'd7);

        do_reset();
        prog = '{enc_i(5, 0, 1), enc_i(6, 0, 2),
                 enc_r(7'b0000000, 2, 1, 3), 32'd0};
        load_prog();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        nvalid = 0;
        cyc    = 0;
        while (nvalid < 2 && cyc < 100) begin
            if (valid) nvalid++;
            if (nvalid < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("p6_reach_add", nvalid, 32'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("p6_x3", dut.rf_q[3], 32'd0);
        chk("p6_x1", dut.rf_q[1], 32'd0);
        chk("p6_pc", pc, 32'd0);
        chk("p6_valid", {31'd0, valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("p6_idle", 32'(dut.state_q), 32'd0);
        chk("p6_pc_idle", pc, 32'd0);
        run(200);
        chk("p6_rerun_x3", dut.rf_q[3], 32'd11);
        chk("p6_rerun_n", nvalid, 32'd3);

        do_reset();
        prog = '{enc_r(7'b0100000, 2, 1, 4), 32'd0};
        load_prog();
        run(200);
        chk("p7_sub_zero", dut.rf_q[4], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
